// File: rtl/i2c_bringup_pkg.sv
// rtl/i2c_bringup_pkg.sv - shared state encodings and width helper for the I2C bring-up sequencer
//
// Purpose: state encodings (also exported on state_out for LED/7-seg debug)
//          and the device-index width function used by the sequencer ports.
// Ports:   none (package).

package i2c_bringup_pkg;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_STARTUP    = 4'd1;
  localparam logic [3:0] S_INIT_START = 4'd2;
  localparam logic [3:0] S_INIT_WAIT  = 4'd3;
  localparam logic [3:0] S_RD_START   = 4'd4;
  localparam logic [3:0] S_RD_WAIT    = 4'd5;
  localparam logic [3:0] S_NEXT       = 4'd6;

  // Device index width: at least one bit even for a single device.
  function automatic int dev_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/i2c_bringup_seq_us_tick_gen.sv
// rtl/i2c_bringup_seq_us_tick_gen.sv - one-cycle microsecond tick enable from the system clock
//
// Purpose: modulo-TICK_DIV counter; tick is high for one clk in every TICK_DIV.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous, active-high
//   tick   out 1  one-cycle enable, period TICK_DIV clocks

module us_tick_gen #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/i2c_bringup_seq.sv
// rtl/i2c_bringup_seq.sv - power-up sequencer and register-read dispatcher for NUM_DEV I2C devices
//
// Purpose: after reset waits STARTUP_US, kicks each device's init engine in
//          turn (settle window, timeout, bounded retries, sticky fail), then
//          serves register-read requests to the per-device read engines.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   init_start/init_done  per-device init engine start pulse / done level
//   rd_req, rd_dev        read request (rising edge) and target device index
//   rd_start/rd_done      per-device read engine start pulse / done level
//   rd_ok, rd_err         one-cycle read result pulses
//   all_init, fail        bring-up complete flag, sticky per-device failure
//   busy, state_out       not-idle flag and raw state for debug display

module i2c_bringup_seq
  import i2c_bringup_pkg::*;
#(
  parameter int NUM_DEV         = 2,
  parameter int TICK_DIV        = 50,
  parameter int STARTUP_US      = 500000,
  parameter int INIT_SETTLE_US  = 500000,
  parameter int INIT_TIMEOUT_US = 1000000,
  parameter int TXN_TIMEOUT_US  = 100,
  parameter int MAX_RETRY       = 3,
  parameter int TW              = 32,
  parameter int DW              = dev_w(NUM_DEV)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [NUM_DEV-1:0] init_start,
  input  logic [NUM_DEV-1:0] init_done,
  input  logic               rd_req,
  input  logic [DW-1:0]      rd_dev,
  output logic [NUM_DEV-1:0] rd_start,
  input  logic [NUM_DEV-1:0] rd_done,
  output logic               rd_ok,
  output logic               rd_err,
  output logic               all_init,
  output logic [NUM_DEV-1:0] fail,
  output logic               busy,
  output logic [3:0]         state_out
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [3:0]         r_state;
  logic [DW-1:0]      r_dev;
  logic [DW-1:0]      r_sel;
  logic [RW-1:0]      r_retry;
  logic [TW-1:0]      r_timer;
  logic               r_rd_req_d;
  logic               r_rd_req_q;
  logic [NUM_DEV-1:0] r_fail;
  logic               r_all_init;
  logic               r_rd_ok;
  logic               r_rd_err;

  logic               w_tick;
  logic               w_rd_edge;
  logic               w_rd_oor;
  logic [31:0]        w_rd_dev_ext;
  logic [NUM_DEV-1:0] w_dev_oh;
  logic [NUM_DEV-1:0] w_sel_oh;

  us_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // rd_req is registered once before edge detection; this gives the
  // two-clock request-to-rd_start latency and keeps the board input off
  // the state logic. Both stages reset high so a request line already
  // high at reset release is not taken as a new edge.
  assign w_rd_edge    = r_rd_req_d & ~r_rd_req_q;
  assign w_rd_dev_ext = 32'(rd_dev);
  assign w_rd_oor     = (w_rd_dev_ext >= 32'(NUM_DEV));

  always_comb begin
    w_dev_oh = '0;
    w_sel_oh = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      w_dev_oh[i] = (r_dev == DW'(i));
      w_sel_oh[i] = (r_sel == DW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_STARTUP;
      r_dev      <= '0;
      r_sel      <= '0;
      r_retry    <= '0;
      r_timer    <= '0;
      r_rd_req_d <= 1'b1;
      r_rd_req_q <= 1'b1;
      r_fail     <= '0;
      r_all_init <= 1'b0;
      r_rd_ok    <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_req_d <= rd_req;
      r_rd_req_q <= r_rd_req_d;
      r_rd_ok    <= 1'b0;
      r_rd_err   <= 1'b0;

      // Saturating microsecond timer; every state change below also
      // writes r_timer <= 0, which overrides this increment.
      if (w_tick && (r_timer != '1)) begin
        r_timer <= r_timer + 1'b1;
      end

      case (r_state)
        S_STARTUP: begin
          if (r_timer == TW'(STARTUP_US)) begin
            r_state <= S_INIT_START;
            r_timer <= '0;
          end
        end

        S_INIT_START: begin
          r_state <= S_INIT_WAIT;
          r_timer <= '0;
        end

        S_INIT_WAIT: begin
          // Success is tested first so it wins a same-cycle timeout.
          if (init_done[r_dev] && (r_timer >= TW'(INIT_SETTLE_US))) begin
            r_retry <= '0;
            r_state <= S_NEXT;
            r_timer <= '0;
          end else if (r_timer == TW'(INIT_TIMEOUT_US)) begin
            r_timer <= '0;
            if (32'(r_retry) < 32'(MAX_RETRY)) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_INIT_START;
            end else begin
              r_fail[r_dev] <= 1'b1;
              r_retry       <= '0;
              r_state       <= S_NEXT;
            end
          end
        end

        S_NEXT: begin
          r_timer <= '0;
          if (r_dev == DW'(NUM_DEV - 1)) begin
            r_all_init <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_dev   <= r_dev + 1'b1;
            r_state <= S_INIT_START;
          end
        end

        S_IDLE: begin
          if (w_rd_edge) begin
            if (w_rd_oor) begin
              r_rd_err <= 1'b1;
            end else begin
              r_sel   <= rd_dev;
              r_state <= S_RD_START;
              r_timer <= '0;
            end
          end
        end

        S_RD_START: begin
          r_state <= S_RD_WAIT;
          r_timer <= '0;
        end

        S_RD_WAIT: begin
          // Completion is tested first so it wins a same-cycle timeout.
          if (rd_done[r_sel]) begin
            r_rd_ok <= 1'b1;
            r_state <= S_IDLE;
            r_timer <= '0;
          end else if (r_timer == TW'(TXN_TIMEOUT_US)) begin
            r_rd_err <= 1'b1;
            r_state  <= S_IDLE;
            r_timer  <= '0;
          end
        end

        default: begin
          r_state <= S_STARTUP;
          r_timer <= '0;
        end
      endcase
    end
  end

  // Start pulses decode straight from state; masking with reset keeps a
  // reset landing in a START state from leaking a pulse in that cycle.
  assign init_start = (r_state == S_INIT_START && !reset) ? w_dev_oh : '0;
  assign rd_start   = (r_state == S_RD_START && !reset) ? w_sel_oh : '0;
  assign rd_ok      = r_rd_ok;
  assign rd_err     = r_rd_err;
  assign all_init   = r_all_init;
  assign fail       = r_fail;
  assign busy       = (r_state != S_IDLE);
  assign state_out  = r_state;

endmodule

// File: tb/tb_i2c_bringup_seq.sv
// tb/tb_i2c_bringup_seq.sv - directed self-checking bench for i2c_bringup_seq

module tb_i2c_bringup_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] init_done, rd_done, init_start, rd_start, fail;
  logic       rd_req, rd_ok, rd_err, all_init, busy;
  logic [0:0] rd_dev;
  logic [3:0] state_out;

  logic [2:0] init_done3, rd_done3, init_start3, rd_start3, fail3;
  logic       rd_req3, rd_ok3, rd_err3, all_init3, busy3;
  logic [1:0] rd_dev3;
  logic [3:0] state_out3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_bringup_seq #(
    .NUM_DEV(2), .TICK_DIV(2), .STARTUP_US(10), .INIT_SETTLE_US(5),
    .INIT_TIMEOUT_US(20), .TXN_TIMEOUT_US(4), .MAX_RETRY(1), .TW(32)
  ) u_dut (
    .clk(clk), .reset(reset), .init_start(init_start), .init_done(init_done),
    .rd_req(rd_req), .rd_dev(rd_dev), .rd_start(rd_start), .rd_done(rd_done),
    .rd_ok(rd_ok), .rd_err(rd_err), .all_init(all_init), .fail(fail),
    .busy(busy), .state_out(state_out)
  );

  // Three-device instance: with two devices the index is one bit wide and
  // cannot express an out-of-range request.
  i2c_bringup_seq #(
    .NUM_DEV(3), .TICK_DIV(2), .STARTUP_US(10), .INIT_SETTLE_US(5),
    .INIT_TIMEOUT_US(20), .TXN_TIMEOUT_US(4), .MAX_RETRY(1), .TW(32)
  ) u_dut3 (
    .clk(clk), .reset(reset), .init_start(init_start3), .init_done(init_done3),
    .rd_req(rd_req3), .rd_dev(rd_dev3), .rd_start(rd_start3), .rd_done(rd_done3),
    .rd_ok(rd_ok3), .rd_err(rd_err3), .all_init(all_init3), .fail(fail3),
    .busy(busy3), .state_out(state_out3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, t1, c0, c1, ts, te, tok, cok, cerr, cst, smax, tp0, tp1;
    logic [1:0] sv;
    logic [2:0] sv3;

    reset = 1'b1; init_done = 2'b11; rd_done = 2'b00; rd_req = 1'b0; rd_dev = 1'b0;
    init_done3 = 3'b111; rd_done3 = 3'b000; rd_req3 = 1'b0; rd_dev3 = 2'd0;
    @(negedge clk);
    step(); step();

    // Reset state
    chk("rst_state", 32'(state_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_outs", {init_start, rd_start, fail, rd_ok, rd_err, all_init}, 32'd0);

    // 1: all devices initialise
    reset = 1'b0;
    n = 0; t0 = -1; t1 = -1; c0 = 0; c1 = 0;
    for (int i = 0; i < 300; i++) begin
      step(); n++;
      if (init_start[0]) begin c0++; if (t0 < 0) t0 = n; end
      if (init_start[1]) begin c1++; if (t1 < 0) t1 = n; end
      if (all_init) break;
    end
    chk("t1_start0_at21", 32'(t0), 32'd21);
    chk("t1_gap_in_range", 32'((t1 - t0 >= 11) && (t1 - t0 <= 24)), 32'd1);
    chk("t1_pulse_counts", 32'({c0[7:0], c1[7:0]}), 32'h0101);
    chk("t1_all_init", 32'(all_init), 32'd1);
    chk("t1_fail", 32'(fail), 32'd0);
    step();
    chk("t1_state_idle", 32'(state_out), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // 3: read of device 1, done three clocks after rd_start
    rd_dev = 1'b1; rd_req = 1'b1;
    n = 0; ts = -1; sv = '0; tok = -1; cok = 0; cerr = 0;
    for (int i = 0; i < 12; i++) begin
      step(); n++;
      if (rd_start != 0 && ts < 0) begin ts = n; sv = rd_start; end
      if (rd_ok) begin cok++; tok = n; end
      if (rd_err) cerr++;
      if (n == 5) rd_done = 2'b10;
    end
    chk("t3_rd_start_at2", 32'(ts), 32'd2);
    chk("t3_rd_start_val", 32'(sv), 32'd2);
    chk("t3_rd_ok_once", 32'(cok), 32'd1);
    chk("t3_rd_ok_at6", 32'(tok), 32'd6);
    chk("t3_no_err", 32'(cerr), 32'd0);
    chk("t3_state_idle", 32'(state_out), 32'd0);
    rd_done = 2'b00; rd_req = 1'b0;
    step(); step(); step();

    // 4: read of device 0 that never completes
    rd_dev = 1'b0; rd_req = 1'b1;
    n = 0; ts = -1; sv = '0; te = -1; cok = 0; cerr = 0;
    for (int i = 0; i < 30; i++) begin
      step(); n++;
      if (rd_start != 0 && ts < 0) begin ts = n; sv = rd_start; end
      if (rd_ok) cok++;
      if (rd_err) begin cerr++; if (te < 0) te = n; end
    end
    chk("t4_rd_start_val", 32'(sv), 32'd1);
    chk("t4_err_gap", 32'((te - ts >= 8) && (te - ts <= 11)), 32'd1);
    chk("t4_err_once", 32'(cerr), 32'd1);
    chk("t4_no_ok", 32'(cok), 32'd0);
    chk("t4_state_idle", 32'(state_out), 32'd0);
    rd_req = 1'b0;
    step(); step(); step();

    // 5: out-of-range index on the three-device instance, then an in-range one
    chk("t5_dut3_all_init", 32'(all_init3), 32'd1);
    rd_dev3 = 2'd3; rd_req3 = 1'b1;
    n = 0; te = -1; cst = 0; smax = 0;
    for (int i = 0; i < 8; i++) begin
      step(); n++;
      if (rd_err3 && te < 0) te = n;
      if (rd_start3 != 0) cst++;
      if (int'(state_out3) > smax) smax = int'(state_out3);
    end
    chk("t5_err_at2", 32'(te), 32'd2);
    chk("t5_no_start", 32'(cst), 32'd0);
    chk("t5_stay_idle", 32'(smax), 32'd0);
    rd_req3 = 1'b0; step(); step();
    rd_dev3 = 2'd2; rd_req3 = 1'b1; sv3 = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rd_start3 != 0) sv3 = rd_start3;
    end
    chk("t5_dev2_rd_start", 32'(sv3), 32'd4);
    rd_req3 = 1'b0;

    // 2: device 1 never reports done -> one retry, then failed
    init_done = 2'b01;
    reset = 1'b1; step(); reset = 1'b0;
    n = 0; c1 = 0; tp0 = -1; tp1 = -1;
    for (int i = 0; i < 400; i++) begin
      step(); n++;
      if (init_start[1]) begin
        c1++;
        if (tp0 < 0) tp0 = n; else if (tp1 < 0) tp1 = n;
      end
      if (all_init) break;
    end
    chk("t2_dev1_pulses", 32'(c1), 32'd2);
    chk("t2_retry_gap", 32'((tp1 - tp0 >= 40) && (tp1 - tp0 <= 43)), 32'd1);
    chk("t2_fail", 32'(fail), 32'd2);
    chk("t2_all_init", 32'(all_init), 32'd1);
    step();

    // Failed device still serves reads
    rd_done = 2'b10; rd_dev = 1'b1; rd_req = 1'b1;
    n = 0; tok = -1;
    for (int i = 0; i < 8; i++) begin
      step(); n++;
      if (rd_ok && tok < 0) tok = n;
    end
    chk("t2_failed_dev_read_ok", 32'(tok), 32'd4);
    rd_req = 1'b0; rd_done = 2'b00; step();

    // Reset from IDLE clears the sticky flags
    reset = 1'b1; step();
    chk("rst_clears", {state_out, fail, 1'b0, all_init}, {4'd1, 2'b00, 1'b0, 1'b0});

    // 6: reset during INIT_WAIT of device 1
    reset = 1'b0;
    t1 = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (init_start[1]) begin t1 = i; break; end
    end
    chk("t6_reached_dev1", 32'(t1 >= 0), 32'd1);
    step(); step(); step();
    chk("t6_in_init_wait", 32'(state_out), 32'd3);
    reset = 1'b1; step();
    chk("t6_state_startup", 32'(state_out), 32'd1);
    chk("t6_cleared", {init_start, rd_start, fail, all_init}, 32'd0);
    init_done = 2'b11;
    reset = 1'b0;
    n = 0; t0 = -1;
    for (int i = 0; i < 300; i++) begin
      step(); n++;
      if (init_start[0] && t0 < 0) t0 = n;
      if (all_init) break;
    end
    chk("t6_restart_start0_at21", 32'(t0), 32'd21);
    chk("t6_all_init", 32'(all_init), 32'd1);
    chk("t6_fail", 32'(fail), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
